// File: rtl/bcp_scheduler.sv
// -----------------------------------------------------------------------------
// bcp_scheduler
//
// Sequences one Boolean-constraint-propagation pass for a single assigned
// variable. It fetches the half-open clause list [start,end) for the variable
// from the range table. It streams clause-evaluation requests to the evaluator
// with a bounded number in flight. It forwards unit implications to the imply
// stack and latches the first conflicting clause. It reports completion with
// a one-cycle done pulse.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   start, var_in, val_in begin a pass for var_in = val_in (sampled in IDLE)
//   busy                  high whenever a pass is in progress
//   done, conflict,       one-cycle completion pulse with result; the clause
//   conflict_clause       is the first one reported as falsified
//   range_rd_en/_var      range table read request (data returns next cycle)
//   range_start/_end      clause list bounds, half-open
//   eval_valid/_ready     evaluation request handshake
//   eval_clause/_var/_val clause address plus the literal being propagated
//   res_valid/_ready      in-order evaluation results
//   res_unit/_conflict    result kind; res_var/_val is the implied literal
//   res_clause            clause the result belongs to
//   imply_push/_var/_val  push port toward the imply stack
//   imply_full            imply stack cannot accept a push
// -----------------------------------------------------------------------------
module bcp_scheduler #(
  parameter int NUM_VARIABLE    = 128,
  parameter int VARIABLE_INDEX  = 6,
  parameter int CLAUSE_INDEX    = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [VARIABLE_INDEX:0]   var_in,
  input  logic                      val_in,
  output logic                      busy,
  output logic                      done,
  output logic                      conflict,
  output logic [CLAUSE_INDEX:0]     conflict_clause,
  output logic                      range_rd_en,
  output logic [VARIABLE_INDEX:0]   range_rd_var,
  input  logic [CLAUSE_INDEX:0]     range_start,
  input  logic [CLAUSE_INDEX:0]     range_end,
  output logic                      eval_valid,
  input  logic                      eval_ready,
  output logic [CLAUSE_INDEX:0]     eval_clause,
  output logic [VARIABLE_INDEX:0]   eval_var,
  output logic                      eval_val,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic                      res_unit,
  input  logic                      res_conflict,
  input  logic [VARIABLE_INDEX:0]   res_var,
  input  logic                      res_val,
  input  logic [CLAUSE_INDEX:0]     res_clause,
  output logic                      imply_push,
  output logic [VARIABLE_INDEX:0]   imply_var,
  output logic                      imply_val,
  input  logic                      imply_full
);

  localparam int VW = VARIABLE_INDEX + 1;
  localparam int CW = CLAUSE_INDEX + 1;

  // The in-flight counter is three bits wide, so the limit is kept in that width.
  localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUTSTANDING);

  // A variable ID field too narrow for the variable count would alias variables;
  // such a configuration never leaves IDLE so the mistake surfaces at once.
  localparam bit VAR_RANGE_OK_C = (NUM_VARIABLE <= (1 << VW));

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RANGE = 3'd1,
    LOAD  = 3'd2,
    ISSUE = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [VW-1:0]   var_r;
  logic            val_r;
  logic [CW-1:0]   ptr_r;
  logic [CW-1:0]   limit_r;
  logic [2:0]      outstanding_r;
  logic [2:0]      outstanding_next_s;
  logic            conflict_r;
  logic [CW-1:0]   conflict_clause_r;

  logic            eval_valid_s;
  logic            issue_hs_s;
  logic            res_accept_s;
  logic            imply_push_s;
  logic            start_accept_s;

  // Handshake and acceptance qualifiers shared by the FSM and the datapath.
  // Results with nothing in flight are stale (e.g. from before a reset) and
  // are dropped rather than counted.
  assign start_accept_s = start & VAR_RANGE_OK_C;
  assign res_accept_s   = res_valid & ~imply_full & (outstanding_r != 3'd0);
  assign eval_valid_s   = (state_r == ISSUE) & (ptr_r < limit_r) & ~conflict_r
                          & (outstanding_r < MAX_OUT_C);
  assign issue_hs_s     = eval_valid_s & eval_ready;
  assign imply_push_s   = res_accept_s & res_unit & ~conflict_r;

  // Next value of the in-flight counter; an issue and a retire in the same
  // cycle cancel out.
  always_comb begin
    outstanding_next_s = outstanding_r;
    if (issue_hs_s && !res_accept_s) begin
      outstanding_next_s = outstanding_r + 3'd1;
    end else if (!issue_hs_s && res_accept_s) begin
      outstanding_next_s = outstanding_r - 3'd1;
    end else begin
      outstanding_next_s = outstanding_r;
    end
  end

  // Next-state logic for the pass sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_accept_s) begin
          state_s = RANGE;
        end else begin
          state_s = IDLE;
        end
      end
      RANGE: begin
        state_s = LOAD;
      end
      LOAD: begin
        if (range_start >= range_end) begin
          state_s = DONE;
        end else begin
          state_s = ISSUE;
        end
      end
      ISSUE: begin
        if ((ptr_r == limit_r) || conflict_r) begin
          state_s = DRAIN;
        end else begin
          state_s = ISSUE;
        end
      end
      DRAIN: begin
        // Finish on the very cycle the last in-flight result retires.
        if (outstanding_next_s == 3'd0) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latched literal; captured only when a pass is accepted in IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      var_r <= {VW{1'b0}};
      val_r <= 1'b0;
    end else if (state_r == IDLE && start_accept_s) begin
      var_r <= var_in;
      val_r <= val_in;
    end
  end

  // Clause pointer and limit. The pointer only advances on a handshake, which
  // requires pointer < limit, so it stops at limit and cannot wrap even when
  // limit is the all-ones address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r   <= {CW{1'b0}};
      limit_r <= {CW{1'b0}};
    end else if (state_r == LOAD) begin
      ptr_r   <= range_start;
      limit_r <= range_end;
    end else if (issue_hs_s) begin
      ptr_r   <= ptr_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // In-flight evaluation counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding_r <= 3'd0;
    end else begin
      outstanding_r <= outstanding_next_s;
    end
  end

  // Conflict latch: first falsified clause wins, cleared when a new pass starts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_r        <= 1'b0;
      conflict_clause_r <= {CW{1'b0}};
    end else if (state_r == IDLE && start_accept_s) begin
      conflict_r        <= 1'b0;
      conflict_clause_r <= {CW{1'b0}};
    end else if (res_accept_s && res_conflict && !conflict_r) begin
      conflict_r        <= 1'b1;
      conflict_clause_r <= res_clause;
    end
  end

  // Output decode. Everything except the result back-pressure and the push
  // port is a function of registered state. The push data is zeroed when no
  // push is taking place so idle outputs stay quiet.
  assign busy            = (state_r != IDLE);
  assign done            = (state_r == DONE);
  assign conflict        = (state_r == DONE) & conflict_r;
  assign conflict_clause = ((state_r == DONE) && conflict_r) ? conflict_clause_r
                                                              : {CW{1'b0}};
  assign range_rd_en     = (state_r == RANGE);
  assign range_rd_var    = var_r;
  assign eval_valid      = eval_valid_s;
  assign eval_clause     = ptr_r;
  assign eval_var        = var_r;
  assign eval_val        = val_r;
  assign res_ready       = ~imply_full;
  assign imply_push      = imply_push_s;
  assign imply_var       = imply_push_s ? res_var : {VW{1'b0}};
  assign imply_val       = imply_push_s & res_val;

endmodule

// File: tb/tb_bcp_scheduler.sv
// -----------------------------------------------------------------------------
// tb_bcp_scheduler
//
// Directed bench for bcp_scheduler. Inputs change 2 time units after each
// rising edge and outputs are sampled 1 unit later. Cycle numbers in the
// comments count from the cycle in which start is driven (cycle 0).
// -----------------------------------------------------------------------------
`define CHECK(TAG, OBS, EXP) \
  begin \
    vectors++; \
    assert ((OBS) === (EXP)) else begin \
      miscompares++; \
      $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_bcp_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [6:0] var_in;
  logic       val_in;
  logic       busy;
  logic       done;
  logic       conflict;
  logic [8:0] conflict_clause;
  logic       range_rd_en;
  logic [6:0] range_rd_var;
  logic [8:0] range_start;
  logic [8:0] range_end;
  logic       eval_valid;
  logic       eval_ready;
  logic [8:0] eval_clause;
  logic [6:0] eval_var;
  logic       eval_val;
  logic       res_valid;
  logic       res_ready;
  logic       res_unit;
  logic       res_conflict;
  logic [6:0] res_var;
  logic       res_val;
  logic [8:0] res_clause;
  logic       imply_push;
  logic [6:0] imply_var;
  logic       imply_val;
  logic       imply_full;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  bcp_scheduler dut (
    .clock(clock), .reset(reset), .start(start), .var_in(var_in), .val_in(val_in),
    .busy(busy), .done(done), .conflict(conflict), .conflict_clause(conflict_clause),
    .range_rd_en(range_rd_en), .range_rd_var(range_rd_var),
    .range_start(range_start), .range_end(range_end),
    .eval_valid(eval_valid), .eval_ready(eval_ready), .eval_clause(eval_clause),
    .eval_var(eval_var), .eval_val(eval_val),
    .res_valid(res_valid), .res_ready(res_ready), .res_unit(res_unit),
    .res_conflict(res_conflict), .res_var(res_var), .res_val(res_val),
    .res_clause(res_clause),
    .imply_push(imply_push), .imply_var(imply_var), .imply_val(imply_val),
    .imply_full(imply_full)
  );

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Mid-cycle monitor of output invariants that hold in every cycle.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $error("FAIL mon_done_busy observed=%0h expected=1", busy);
      end
    end
    if (eval_valid === 1'b1) begin
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $error("FAIL mon_eval_busy observed=%0h expected=1", busy);
      end
    end
    if (range_rd_en === 1'b1) begin
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $error("FAIL mon_rd_busy observed=%0h expected=1", busy);
      end
    end
    if (conflict === 1'b1) begin
      vectors++;
      if (done !== 1'b1) begin
        miscompares++;
        $error("FAIL mon_conflict_done observed=%0h expected=1", done);
      end
    end
  end

  int due_q[$];
  int out_m;
  int out_max;
  int issued;
  int done_seen;

  initial begin
    reset = 1'b1; start = 1'b0; var_in = 7'd0; val_in = 1'b0;
    range_start = 9'd0; range_end = 9'd0; eval_ready = 1'b0;
    res_valid = 1'b0; res_unit = 1'b0; res_conflict = 1'b0;
    res_var = 7'd0; res_val = 1'b0; res_clause = 9'd0; imply_full = 1'b0;

    // ---------------- reset state ----------------
    #3;
    `CHECK("rst_busy", busy, 1'b0)
    `CHECK("rst_done", done, 1'b0)
    `CHECK("rst_rd_en", range_rd_en, 1'b0)
    `CHECK("rst_eval_valid", eval_valid, 1'b0)
    `CHECK("rst_push", imply_push, 1'b0)
    `CHECK("rst_res_ready", res_ready, 1'b1)
    imply_full = 1'b1;
    #1;
    `CHECK("rst_res_ready_full", res_ready, 1'b0)
    imply_full = 1'b0;
    step();
    step();
    reset = 1'b0;

    // ---------------- empty range [10,10), minimum latency ----------------
    step(); start = 1'b1; var_in = 7'd5; val_in = 1'b1; #1;             // c0
    `CHECK("t1_c0_busy", busy, 1'b0)
    step(); start = 1'b0; #1;                                            // c1
    `CHECK("t1_c1_rd_en", range_rd_en, 1'b1)
    `CHECK("t1_c1_rd_var", range_rd_var, 7'd5)
    `CHECK("t1_c1_busy", busy, 1'b1)
    step(); range_start = 9'd10; range_end = 9'd10; #1;                  // c2
    `CHECK("t1_c2_rd_en", range_rd_en, 1'b0)
    `CHECK("t1_c2_eval_valid", eval_valid, 1'b0)
    step(); #1;                                                          // c3
    `CHECK("t1_c3_done", done, 1'b1)
    `CHECK("t1_c3_conflict", conflict, 1'b0)
    `CHECK("t1_c3_eval_valid", eval_valid, 1'b0)
    step(); #1;                                                          // c4
    `CHECK("t1_c4_done", done, 1'b0)
    `CHECK("t1_c4_busy", busy, 1'b0)

    // ---------------- range [0,3), two unit results ----------------
    step(); start = 1'b1; var_in = 7'd3; val_in = 1'b0; #1;             // c0
    step(); start = 1'b0; #1;                                            // c1
    step(); range_start = 9'd0; range_end = 9'd3; eval_ready = 1'b1; #1; // c2
    step(); #1;                                                          // c3
    `CHECK("t2_c3_valid", eval_valid, 1'b1)
    `CHECK("t2_c3_clause", eval_clause, 9'd0)
    `CHECK("t2_c3_var", eval_var, 7'd3)
    `CHECK("t2_c3_val", eval_val, 1'b0)
    `CHECK("t2_c3_push", imply_push, 1'b0)
    step(); #1;                                                          // c4
    `CHECK("t2_c4_clause", eval_clause, 9'd1)
    step(); res_valid = 1'b1; res_unit = 1'b1; res_var = 7'd7; res_val = 1'b1;
    res_clause = 9'd0; #1;                                               // c5
    `CHECK("t2_c5_valid", eval_valid, 1'b1)
    `CHECK("t2_c5_clause", eval_clause, 9'd2)
    `CHECK("t2_c5_push", imply_push, 1'b1)
    `CHECK("t2_c5_ivar", imply_var, 7'd7)
    `CHECK("t2_c5_ival", imply_val, 1'b1)
    step(); res_var = 7'd9; res_val = 1'b0; res_clause = 9'd1; #1;     // c6
    `CHECK("t2_c6_valid", eval_valid, 1'b0)
    `CHECK("t2_c6_push", imply_push, 1'b1)
    `CHECK("t2_c6_ivar", imply_var, 7'd9)
    step(); res_unit = 1'b0; res_var = 7'd0; res_clause = 9'd2; #1;    // c7
    `CHECK("t2_c7_push", imply_push, 1'b0)
    `CHECK("t2_c7_done", done, 1'b0)
    step(); res_valid = 1'b0; #1;                                        // c8
    `CHECK("t2_c8_done", done, 1'b1)
    `CHECK("t2_c8_conflict", conflict, 1'b0)
    step(); #1;                                                          // c9
    `CHECK("t2_c9_busy", busy, 1'b0)

    // ---------------- range [0,8), results 6 cycles after issue ----------------
    step(); start = 1'b1; var_in = 7'd8; val_in = 1'b1; #1;             // c0
    step(); start = 1'b0; #1;                                            // c1
    step(); range_start = 9'd0; range_end = 9'd8; #1;                   // c2
    out_m = 0; out_max = 0; issued = 0; done_seen = 0;
    for (int n = 3; n < 40 && done_seen == 0; n++) begin
      step();
      res_valid = (due_q.size() > 0 && due_q[0] == n);
      res_unit = 1'b0; res_conflict = 1'b0;
      #1;
      if (n == 7) `CHECK("t3_c7_stall", eval_valid, 1'b0)
      if (n == 10) begin
        `CHECK("t3_c10_valid", eval_valid, 1'b1)
        `CHECK("t3_c10_clause", eval_clause, 9'd4)
      end
      if (out_m == 4) `CHECK("t3_stall_at_4", eval_valid, 1'b0)
      if (done === 1'b1) done_seen = 1;
      if (res_valid) begin
        void'(due_q.pop_front());
        out_m--;
      end
      if (eval_valid && eval_ready) begin
        due_q.push_back(n + 6);
        out_m++;
        issued++;
      end
      if (out_m > out_max) out_max = out_m;
    end
    res_valid = 1'b0;
    `CHECK("t3_done_seen", done_seen, 1)
    `CHECK("t3_out_max", out_max, 4)
    `CHECK("t3_issued", issued, 8)
    step(); #1;
    `CHECK("t3_idle", busy, 1'b0)

    // ---------------- range [4,9), clause 5 conflicts ----------------
    step(); start = 1'b1; var_in = 7'd1; val_in = 1'b1; #1;             // c0
    step(); start = 1'b0; #1;                                            // c1
    step(); range_start = 9'd4; range_end = 9'd9; #1;                   // c2
    step(); #1;                                                          // c3
    `CHECK("t4_c3_clause", eval_clause, 9'd4)
    step(); #1;                                                          // c4
    `CHECK("t4_c4_clause", eval_clause, 9'd5)
    step(); res_valid = 1'b1; res_clause = 9'd4; #1;                    // c5
    `CHECK("t4_c5_clause", eval_clause, 9'd6)
    step(); res_conflict = 1'b1; res_clause = 9'd5; #1;                 // c6
    `CHECK("t4_c6_clause", eval_clause, 9'd7)
    step(); res_conflict = 1'b0; res_unit = 1'b1; res_var = 7'd20; res_val = 1'b1;
    res_clause = 9'd6; #1;                                               // c7
    `CHECK("t4_c7_valid", eval_valid, 1'b0)
    `CHECK("t4_c7_push", imply_push, 1'b0)
    step(); res_unit = 1'b0; res_conflict = 1'b1; res_clause = 9'd7; #1; // c8
    `CHECK("t4_c8_valid", eval_valid, 1'b0)
    `CHECK("t4_c8_done", done, 1'b0)
    step(); res_valid = 1'b0; res_conflict = 1'b0; #1;                  // c9
    `CHECK("t4_c9_done", done, 1'b1)
    `CHECK("t4_c9_conflict", conflict, 1'b1)
    `CHECK("t4_c9_cclause", conflict_clause, 9'd5)
    step(); #1;                                                          // c10
    `CHECK("t4_c10_busy", busy, 1'b0)
    `CHECK("t4_c10_conflict", conflict, 1'b0)

    // ---------------- imply stack full during a unit result ----------------
    step(); start = 1'b1; var_in = 7'd2; val_in = 1'b0; #1;             // c0
    step(); start = 1'b0; #1;                                            // c1
    step(); range_start = 9'd20; range_end = 9'd21; #1;                 // c2
    step(); #1;                                                          // c3
    `CHECK("t5_c3_clause", eval_clause, 9'd20)
    step(); #1;                                                          // c4
    `CHECK("t5_c4_valid", eval_valid, 1'b0)
    step(); res_valid = 1'b1; res_unit = 1'b1; res_var = 7'd11; res_val = 1'b1;
    res_clause = 9'd20; imply_full = 1'b1; #1;                           // c5
    `CHECK("t5_c5_ready", res_ready, 1'b0)
    `CHECK("t5_c5_push", imply_push, 1'b0)
    step(); start = 1'b1; var_in = 7'd33; #1;                           // c6
    `CHECK("t5_c6_push", imply_push, 1'b0)
    step(); start = 1'b0; #1;                                            // c7
    `CHECK("t5_c7_rd_en", range_rd_en, 1'b0)
    `CHECK("t5_c7_push", imply_push, 1'b0)
    step(); imply_full = 1'b0; #1;                                       // c8
    `CHECK("t5_c8_ready", res_ready, 1'b1)
    `CHECK("t5_c8_push", imply_push, 1'b1)
    `CHECK("t5_c8_ivar", imply_var, 7'd11)
    step(); res_valid = 1'b0; res_unit = 1'b0; #1;                      // c9
    `CHECK("t5_c9_done", done, 1'b1)
    `CHECK("t5_c9_rd_var", range_rd_var, 7'd2)
    step(); #1;                                                          // c10
    `CHECK("t5_c10_busy", busy, 1'b0)

    // ---------------- reset mid-ISSUE, then a clean pass ----------------
    step(); start = 1'b1; var_in = 7'd6; val_in = 1'b1; #1;             // c0
    step(); start = 1'b0; #1;                                            // c1
    step(); range_start = 9'd0; range_end = 9'd8; #1;                   // c2
    step(); #1;                                                          // c3
    step(); #1;                                                          // c4
    step(); eval_ready = 1'b0; #1;                                       // c5
    `CHECK("t6_pre_valid", eval_valid, 1'b1)
    reset = 1'b1; #1;
    `CHECK("t6_rst_busy", busy, 1'b0)
    `CHECK("t6_rst_valid", eval_valid, 1'b0)
    `CHECK("t6_rst_ready", res_ready, 1'b1)
    step();
    step(); reset = 1'b0;
    step(); res_valid = 1'b1; res_unit = 1'b1; res_var = 7'd12; #1;
    `CHECK("t6_stale_push", imply_push, 1'b0)
    step(); res_valid = 1'b0; res_unit = 1'b0;
    start = 1'b1; var_in = 7'd2; val_in = 1'b1; eval_ready = 1'b1; #1;  // c0
    step(); start = 1'b0; #1;                                            // c1
    `CHECK("t6_c1_rd_en", range_rd_en, 1'b1)
    `CHECK("t6_c1_rd_var", range_rd_var, 7'd2)
    step(); range_start = 9'd30; range_end = 9'd31; #1;                 // c2
    step(); #1;                                                          // c3
    `CHECK("t6_c3_valid", eval_valid, 1'b1)
    `CHECK("t6_c3_clause", eval_clause, 9'd30)
    step(); res_valid = 1'b1; res_unit = 1'b1; res_var = 7'd4; res_val = 1'b0;
    res_clause = 9'd30; #1;                                              // c4
    `CHECK("t6_c4_push", imply_push, 1'b1)
    `CHECK("t6_c4_ivar", imply_var, 7'd4)
    step(); res_valid = 1'b0; res_unit = 1'b0; #1;                      // c5
    `CHECK("t6_c5_done", done, 1'b0)
    step(); #1;                                                          // c6
    `CHECK("t6_c6_done", done, 1'b1)
    `CHECK("t6_c6_conflict", conflict, 1'b0)

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
